lane_gene_compactor: RTL and testbench

- Sits directly downstream of the per-lane node/connection deletion stage.
- That stage emits a gene stream with bubbles: deleted genes appear as cycles with valid low.
- This block squeezes out the bubbles and buffers surviving genes in a small FIFO. It emits them in order with contiguous write addresses over a ready/valid interface to the genome write-back memory.
- When the genome ends, it reports per-genome node and connection counts.

---
 rtl/lane_gene_compactor.sv | 121 ++++++++++++
 tb/tb_lane_gene_compactor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_gene_compactor.sv
// Bubble-squeezing gene FIFO between the deletion stage and genome write-back.
// Emits surviving genes in order with contiguous addresses and reports per-genome kind counts.
module lane_gene_compactor #(
    parameter int GENE_SZ = 64,
    parameter int ATTR_SZ = 8,
    parameter int DEPTH   = 8,
    parameter int PTR_SZ  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [GENE_SZ-1:0] gene_in,
    input  logic               in_valid,
    input  logic               in_kind,
    input  logic               genome_end,
    output logic [GENE_SZ-1:0] out_gene,
    output logic               out_kind,
    output logic [ATTR_SZ-1:0] out_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ATTR_SZ-1:0] node_cnt,
    output logic [ATTR_SZ-1:0] conn_cnt,
    output logic               done,
    output logic               overflow,
    output logic               order_err
);

    typedef enum logic [1:0] {COLLECT, DRAIN, REPORT} state_t;

    localparam logic [PTR_SZ:0]  FULL    = (PTR_SZ+1)'(DEPTH);
    localparam logic [ATTR_SZ-1:0] CNT_MAX = '1;

    state_t              state, state_nx;
    logic [GENE_SZ:0]    mem [DEPTH];
    logic [PTR_SZ-1:0]   wr_ptr, rd_ptr;
    logic [PTR_SZ:0]     fill;
    logic                pop, push, drop;
    logic [ATTR_SZ-1:0]  addr_q, node_q, conn_q;
    logic                seen_conn, ovf_q, oerr_q;

    // Head entry is gated so every output reads 0 while the FIFO is empty or in reset.
    assign out_valid = (fill != '0);
    assign out_gene  = out_valid ? mem[rd_ptr][GENE_SZ-1:0] : '0;
    assign out_kind  = out_valid & mem[rd_ptr][GENE_SZ];
    assign out_addr  = addr_q;
    assign node_cnt  = node_q;
    assign conn_cnt  = conn_q;
    assign done      = (state == REPORT);
    assign overflow  = ovf_q;
    assign order_err = oerr_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_nx = state;
        push     = 1'b0;
        drop     = 1'b0;
        case (state)
            COLLECT: begin
                if (in_valid) begin
                    if (fill != FULL || pop) push = 1'b1;
                    else                     drop = 1'b1;
                end
                if (genome_end) state_nx = DRAIN;
            end
            DRAIN: begin
                drop = in_valid;
                // Empty after this cycle's pop: fill is 0, or 1 with a pop.
                if (fill == (PTR_SZ+1)'(pop)) state_nx = REPORT;
            end
            REPORT: begin
                drop     = in_valid;
                state_nx = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
    end

    // NOTE: the gene storage has no reset; validity comes from fill, and this keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_kind, gene_in};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            addr_q    <= '0;
            node_q    <= '0;
            conn_q    <= '0;
            seen_conn <= 1'b0;
            ovf_q     <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            state <= state_nx;
            fill  <= fill + (PTR_SZ+1)'(push) - (PTR_SZ+1)'(pop);
            if (push) wr_ptr <= wr_ptr + PTR_SZ'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_SZ'(1);
            if (drop) ovf_q <= 1'b1;
            if (push && in_kind) seen_conn <= 1'b1;
            if (push && !in_kind && seen_conn) oerr_q <= 1'b1;

            if (state == REPORT) begin
                addr_q    <= '0;
                node_q    <= '0;
                conn_q    <= '0;
                seen_conn <= 1'b0;
            end else if (pop) begin
                addr_q <= addr_q + ATTR_SZ'(1);
                if (out_kind) begin
                    if (conn_q != CNT_MAX) conn_q <= conn_q + ATTR_SZ'(1);
                end else begin
                    if (node_q != CNT_MAX) node_q <= node_q + ATTR_SZ'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_gene_compactor.sv
// Self-checking bench for lane_gene_compactor: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_lane_gene_compactor;

    localparam int GENE_SZ = 64;
    localparam int ATTR_SZ = 8;
    localparam int DEPTH   = 8;
    localparam int PTR_SZ  = 3;
    localparam int CNT_MAX = 255;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [GENE_SZ-1:0] gene_in = '0;
    logic               in_valid = 1'b0;
    logic               in_kind = 1'b0;
    logic               genome_end = 1'b0;
    logic [GENE_SZ-1:0] out_gene;
    logic               out_kind;
    logic [ATTR_SZ-1:0] out_addr;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [ATTR_SZ-1:0] node_cnt;
    logic [ATTR_SZ-1:0] conn_cnt;
    logic               done;
    logic               overflow;
    logic               order_err;

    lane_gene_compactor #(
        .GENE_SZ(GENE_SZ), .ATTR_SZ(ATTR_SZ), .DEPTH(DEPTH), .PTR_SZ(PTR_SZ)
    ) dut (
        .clk(clk), .rst(rst), .gene_in(gene_in), .in_valid(in_valid), .in_kind(in_kind),
        .genome_end(genome_end), .out_gene(out_gene), .out_kind(out_kind),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .node_cnt(node_cnt), .conn_cnt(conn_cnt), .done(done),
        .overflow(overflow), .order_err(order_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: genome-level view of buffered genes, counts and flags.
    logic [GENE_SZ:0] q[$];
    int m_addr, m_node, m_conn;
    bit m_seen, m_ovf, m_oerr, m_ending, m_report;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_addr = 0; m_node = 0; m_conn = 0;
        m_seen = 0; m_ovf = 0; m_oerr = 0; m_ending = 0; m_report = 0;
    endtask

    // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset();
        in_valid = 0; genome_end = 0; out_ready = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_gene",  out_gene,  0);
        check("rst_out_kind",  out_kind,  0);
        check("rst_out_addr",  out_addr,  0);
        check("rst_done",      done,      0);
        check("rst_node_cnt",  node_cnt,  0);
        check("rst_conn_cnt",  conn_cnt,  0);
        check("rst_overflow",  overflow,  0);
        check("rst_order_err", order_err, 0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: drive inputs, compare outputs at the falling edge, advance the model.
    task automatic cycle(input bit iv, input bit kind, input bit ge, input bit rdy);
        logic [GENE_SZ-1:0] g;
        logic [GENE_SZ:0]   h;
        int  sz;
        bit  pop;
        g = {$urandom, $urandom};
        gene_in = g; in_valid = iv; in_kind = kind; genome_end = ge; out_ready = rdy;
        @(negedge clk);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("out_gene", out_gene, q[0][GENE_SZ-1:0]);
            check("out_kind", out_kind, q[0][GENE_SZ]);
        end
        check("out_addr", out_addr, m_addr);
        check("done", done, m_report);
        if (m_report) begin
            check("node_cnt", node_cnt, m_node);
            check("conn_cnt", conn_cnt, m_conn);
        end
        check("overflow", overflow, m_ovf);
        check("order_err", order_err, m_oerr);

        sz  = q.size();
        pop = (sz != 0) && rdy;
        if (m_report) begin
            if (iv) m_ovf = 1;
            m_report = 0;
            m_addr = 0; m_node = 0; m_conn = 0; m_seen = 0;
        end else begin
            if (pop) begin
                h = q.pop_front();
                m_addr = (m_addr + 1) % 256;
                if (h[GENE_SZ]) m_conn = (m_conn < CNT_MAX) ? m_conn + 1 : CNT_MAX;
                else            m_node = (m_node < CNT_MAX) ? m_node + 1 : CNT_MAX;
            end
            if (iv) begin
                if (!m_ending && (sz < DEPTH || pop)) begin
                    if (!kind && m_seen) m_oerr = 1;
                    if (kind) m_seen = 1;
                    q.push_back({kind, g});
                end else begin
                    m_ovf = 1;
                end
            end
            if (m_ending) begin
                if (q.size() == 0) begin
                    m_ending = 0;
                    m_report = 1;
                end
            end else if (ge) begin
                m_ending = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, rdy);
    endtask

    int done_seen;

    initial begin
        model_clear();
        do_reset();
        idle(2, 1);

        // Reset with three genes buffered; no done may follow.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        do_reset();
        idle(4, 1);

        // Compaction: 5 node + 3 connection genes with bubbles, then genome end.
        for (int i = 0; i < 8; i++) begin
            cycle(1, i >= 5, 0, 1);
            cycle(0, 0, 0, 1);
        end
        cycle(0, 0, 1, 1);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_report) begin
                done_seen++;
                check("cmp_node_cnt_5", m_node, 5);
                check("cmp_conn_cnt_3", m_conn, 3);
            end
            cycle(0, 0, 0, 1);
        end
        check("cmp_done_pulses", done_seen, 1);

        // Backpressure: 9 genes into a stalled FIFO, 9th dropped; then drain in order.
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0);
        check("bp_model_fill", q.size(), DEPTH);
        idle(10, 1);
        cycle(0, 0, 1, 1);
        idle(4, 1);

        // Full FIFO with simultaneous pop accepts the incoming gene.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 1, 0, 1);
        check("full_pop_fill", q.size(), DEPTH);
        // Genome end with coincident gene, then a gene during DRAIN overflows.
        cycle(1, 1, 1, 0);
        cycle(1, 1, 0, 0);
        idle(14, 1);

        // Ordering error, then 300 connection genes to saturate conn_cnt and wrap out_addr.
        do_reset();
        cycle(1, 1, 0, 1);
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 300; i++) cycle(1, 1, 0, 1);
        cycle(0, 0, 1, 1);
        idle(4, 1);

        // Random traffic with occasional genome ends and resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0);
        end
        idle(20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
